parking_controller: RTL and testbench

PARKING_CONTROLLER -- requirements
Module: parking_controller

---
 rtl/parking_controller.sv | 102 ++++++++++
 tb/tb_parking_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/parking_controller.sv
// Four-slot parking controller: synchronized entry/exit sensing, occupancy
// tracking, and a blinking door light restarted by every accepted event.
module parking_controller #(
   parameter int unsigned BLINK_HALF  = 10_000_000,
   parameter int unsigned BLINK_COUNT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_sensor,
   input  logic       exit_sensor,
   input  logic [1:0] switch,
   output logic [3:0] parking_slots,
   output logic [2:0] capacity,
   output logic       full,
   output logic       door_pulse,
   output logic       door_open_light
);
   localparam int unsigned HALF_W  = $clog2(BLINK_HALF + 1);
   localparam int unsigned PHASE_W = $clog2(2 * BLINK_COUNT + 1);
   localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(BLINK_HALF - 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * BLINK_COUNT - 1);

   typedef enum logic {IDLE, BLINK} light_state_t;
   light_state_t state, state_next;

   // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection
   logic [2:0]         entry_sync, exit_sync;
   logic               entry_rise, exit_rise;
   logic [3:0]         slots_next;
   logic               pulse_next, light_next;
   logic [HALF_W-1:0]  half_cnt, half_next;
   logic [PHASE_W-1:0] phase_cnt, phase_next;

   always_ff @(posedge clk) begin
      if (!reset) begin
         entry_sync      <= '0;
         exit_sync       <= '0;
         parking_slots   <= '0;
         door_pulse      <= 1'b0;
         door_open_light <= 1'b0;
         half_cnt        <= '0;
         phase_cnt       <= '0;
         state           <= IDLE;
      end else begin
         entry_sync      <= {entry_sync[1:0], entry_sensor};
         exit_sync       <= {exit_sync[1:0], exit_sensor};
         parking_slots   <= slots_next;
         door_pulse      <= pulse_next;
         door_open_light <= light_next;
         half_cnt        <= half_next;
         phase_cnt       <= phase_next;
         state           <= state_next;
      end
   end

   assign entry_rise = entry_sync[1] & ~entry_sync[2];
   assign exit_rise  = exit_sync[1] & ~exit_sync[2];

   // Simultaneous entry and exit edges cancel each other out.
   always_comb begin
      slots_next = parking_slots;
      pulse_next = 1'b0;
      if (entry_rise && !exit_rise && !parking_slots[switch]) begin
         slots_next[switch] = 1'b1;
         pulse_next         = 1'b1;
      end else if (exit_rise && !entry_rise && parking_slots[switch]) begin
         slots_next[switch] = 1'b0;
         pulse_next         = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      light_next = door_open_light;
      half_next  = half_cnt;
      phase_next = phase_cnt;
      if (door_pulse) begin
         state_next = BLINK;
         light_next = 1'b1;
         half_next  = '0;
         phase_next = '0;
      end else if (state == BLINK) begin
         if (half_cnt == HALF_LAST) begin
            half_next = '0;
            if (phase_cnt == PHASE_LAST) begin
               state_next = IDLE;
               light_next = 1'b0;
               phase_next = '0;
            end else begin
               phase_next = phase_cnt + 1'b1;
               light_next = ~door_open_light;
            end
         end else begin
            half_next = half_cnt + 1'b1;
         end
      end
   end

   assign capacity = 3'd4 - 3'($countones(parking_slots));
   assign full     = &parking_slots;

endmodule

// File: tb/tb_parking_controller.sv
// Randomized bench for parking_controller: stimulus pushes expected slot states,
// a negedge monitor pops them on each door pulse and checks all outputs.
module tb_parking_controller;
   localparam int unsigned H   = 4;
   localparam int unsigned BC  = 2;
   localparam int unsigned SEQ = 2 * H * BC;

   logic       clk = 1'b0;
   logic       reset, entry_sensor, exit_sensor;
   logic [1:0] switch;
   logic [3:0] parking_slots;
   logic [2:0] capacity;
   logic       full, door_pulse, door_open_light;

   always #5 clk = ~clk;

   parking_controller #(.BLINK_HALF(H), .BLINK_COUNT(BC)) dut (
      .clk(clk), .reset(reset), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
      .switch(switch), .parking_slots(parking_slots), .capacity(capacity), .full(full),
      .door_pulse(door_pulse), .door_open_light(door_open_light)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  occ;
   logic [3:0]  mslots = '0;
   int unsigned since = SEQ + 1;
   logic        rst_q;
   logic        mon_en = 1'b0;

   always @(posedge clk) rst_q <= reset;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic light_ref(input int unsigned k);
      if (k == 0 || k > SEQ) return 1'b0;
      return ((k - 1) / H) % 2 == 0;
   endfunction

   function automatic logic [2:0] free_of(input logic [3:0] s);
      int unsigned n = 0;
      for (int i = 0; i < 4; i++) if (!s[i]) n++;
      return 3'(n);
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst_q) begin
            mslots = '0;
            since  = SEQ + 1;
            chk("pulse_in_reset", {7'd0, door_pulse}, 8'd0);
         end else begin
            if (since <= SEQ) since++;
            if (door_pulse) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pulse actual=1 required=0 slots=%b at %0t",
                           parking_slots, $time);
               end else begin
                  mslots = exp_q.pop_front();
               end
            end
         end
         chk("slots", {4'd0, parking_slots}, {4'd0, mslots});
         chk("capacity", {5'd0, capacity}, {5'd0, free_of(mslots)});
         chk("full", {7'd0, full}, {7'd0, mslots == 4'hF});
         chk("light", {7'd0, door_open_light}, {7'd0, light_ref(since)});
         if (door_pulse && rst_q) since = 0;
      end
   end

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) step(1);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL missing_pulse actual=none required=%b at %0t", exp_q[0], $time);
         exp_q.delete();
      end
   endtask

   // kind: 0 entry, 1 exit, 2 both at once
   task automatic do_event(input int kind, input logic [1:0] sw, input int unsigned hold);
      entry_sensor = (kind != 1);
      exit_sensor  = (kind != 0);
      switch       = ~sw;
      if (kind == 0 && !occ[sw]) begin
         occ[sw] = 1'b1;
         exp_q.push_back(occ);
      end else if (kind == 1 && occ[sw]) begin
         occ[sw] = 1'b0;
         exp_q.push_back(occ);
      end
      step(1);
      switch = sw;
      if (hold > 1) step(hold - 1);
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
      step(3);
      drain();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_q.delete();
      occ = '0;
      step(1);
      reset = 1'b1;
   endtask

   // Reset lands while an entry edge is pending; a sensor still high afterwards is a new edge.
   task automatic do_pending_reset(input logic keep, input logic [1:0] sw);
      entry_sensor = 1'b1;
      switch       = sw;
      step(2);
      do_reset();
      if (keep) begin
         occ[sw] = 1'b1;
         exp_q.push_back(occ);
         step(3);
         entry_sensor = 1'b0;
         step(3);
         drain();
      end else begin
         entry_sensor = 1'b0;
         step(6);
      end
   endtask

   initial begin
      reset        = 1'b0;
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
      switch       = 2'd0;
      occ          = '0;
      step(1);
      mon_en = 1'b1;
      step(2);
      reset = 1'b1;
      step(2);

      do_event(0, 2'd2, 3);
      step(20);
      do_event(0, 2'd0, 2);
      do_event(0, 2'd1, 1);
      do_event(0, 2'd3, 2);
      do_event(0, 2'd1, 2);
      step(20);
      do_event(1, 2'd3, 2);
      do_event(1, 2'd3, 2);
      do_event(2, 2'd0, 2);
      do_event(0, 2'd3, 20);
      do_event(1, 2'd0, 1);
      step(1);
      do_event(1, 2'd3, 1);
      step(20);
      do_event(1, 2'd2, 1);
      step(4);
      do_reset();
      step(3);
      do_pending_reset(1'b1, 2'd1);
      do_pending_reset(1'b0, 2'd2);

      for (int n = 0; n < 200; n++) begin
         int unsigned r;
         logic [1:0]  sw;
         r  = $urandom_range(0, 99);
         sw = 2'($urandom_range(0, 3));
         if (r < 4)       do_reset();
         else if (r < 8)  do_pending_reset(1'($urandom_range(0, 1)), sw);
         else if (r < 50) do_event(0, sw, $urandom_range(1, 6));
         else if (r < 85) do_event(1, sw, $urandom_range(1, 6));
         else if (r < 92) do_event(2, sw, $urandom_range(1, 6));
         else             do_event(0, sw, $urandom_range(15, 25));
         step($urandom_range(0, 20));
      end
      step(SEQ + 5);
      chk("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
